// File: rtl/rom_fetch_master.sv
// rom_fetch_master: burst word fetch from a 1-cycle-latency ROM into a
// 2-entry FIFO, with credit-based request pacing and optional checksum.
// Ports: clk_i, rst_ni (async, active low); start_i/base_addr_i/len_i start
// a burst; busy_o/done_o report status; req_o/addr_o/rdata_i form the memory
// side; data_o/valid_o/ready_i form the output stream; checksum_o holds the
// sum of accepted words when ROM_FETCH_CHECKSUM_EN is defined, else 0.
module rom_fetch_master #(
  parameter int MAX_LEN_W = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [31:0]          base_addr_i,
  input  logic [MAX_LEN_W-1:0] len_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 req_o,
  output logic [31:0]          addr_o,
  input  logic [31:0]          rdata_i,
  output logic [31:0]          data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [31:0]          checksum_o
);

  typedef enum logic [1:0] {
    S_IDLE, S_FETCH, S_DRAIN, S_DONE
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [31:0]          r_addr;
  logic [MAX_LEN_W-1:0] r_remain;
  logic                 r_infl;
  logic [31:0]          r_mem [2];
  logic                 r_wptr;
  logic                 r_rptr;
  logic [1:0]           r_cnt;

  logic       w_start;
  logic       w_pop;
  logic       w_push;
  logic [1:0] w_load;
  logic       w_req;
  logic       w_last;
  logic       w_unused;

  assign w_unused = ^base_addr_i[1:0];

  assign w_start = start_i && (r_state == S_IDLE);
  assign valid_o = (r_cnt != 2'd0);
  assign data_o  = valid_o ? r_mem[r_rptr] : 32'd0;
  assign w_pop   = valid_o && ready_i;
  assign w_push  = r_infl;
  assign addr_o  = r_addr;

  // Credit: entries left after this cycle's pop plus the word on the bus.
  // Counting the pop keeps 1 word/cycle with ready_i held high.
  assign w_load = r_cnt - {1'b0, w_pop} + {1'b0, r_infl};
  assign w_req  = (r_state == S_FETCH) && (w_load < 2'd2);
  assign w_last = w_req && (r_remain == MAX_LEN_W'(1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (start_i)
          w_next = (len_i != '0) ? S_FETCH : S_DONE;
      end
      S_FETCH: begin
        if (w_last) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        // Leave as the final word is accepted so done_o follows it directly.
        if (!r_infl &&
            (r_cnt == 2'd0 || (r_cnt == 2'd1 && w_pop)))
          w_next = S_DONE;
      end
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy_o = (r_state == S_FETCH) || (r_state == S_DRAIN);
    done_o = (r_state == S_DONE);
    req_o  = w_req;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_addr   <= 32'd0;
      r_remain <= '0;
      r_infl   <= 1'b0;
      r_mem[0] <= 32'd0;
      r_mem[1] <= 32'd0;
      r_wptr   <= 1'b0;
      r_rptr   <= 1'b0;
      r_cnt    <= 2'd0;
    end else begin
      if (w_start && len_i != '0) begin
        r_addr   <= {base_addr_i[31:2], 2'b00};
        r_remain <= len_i;
      end else if (w_req) begin
        r_addr   <= r_addr + 32'd4;
        r_remain <= r_remain - MAX_LEN_W'(1);
      end
      r_infl <= w_req;
      if (w_push) begin
        r_mem[r_wptr] <= rdata_i;
        r_wptr        <= ~r_wptr;
      end
      if (w_pop) r_rptr <= ~r_rptr;
      r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

`ifdef ROM_FETCH_CHECKSUM_EN
  logic [31:0] r_cks;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)    r_cks <= 32'd0;
    else if (w_start) r_cks <= 32'd0;
    else if (w_pop)   r_cks <= r_cks + data_o;
  end

  assign checksum_o = r_cks;
`else
  assign checksum_o = 32'd0;
`endif

endmodule

// File: tb/tb_rom_fetch_master.sv
// tb_rom_fetch_master: directed bench for rom_fetch_master with a
// request-driven scoreboard and a credit/occupancy model.
module tb_rom_fetch_master;

`ifdef ROM_FETCH_CHECKSUM_EN
  localparam bit CKS = 1'b1;
`else
  localparam bit CKS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start_i = 1'b0;
  logic [31:0] base_addr_i = 32'd0;
  logic [7:0]  len_i = 8'd0;
  logic [31:0] rdata_i;
  logic        ready_i = 1'b0;
  logic        busy_o, done_o, req_o, valid_o;
  logic [31:0] addr_o, data_o, checksum_o;

  always #5 clk = ~clk;

  rom_fetch_master #(.MAX_LEN_W(8)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i),
    .base_addr_i(base_addr_i), .len_i(len_i),
    .busy_o(busy_o), .done_o(done_o), .req_o(req_o),
    .addr_o(addr_o), .rdata_i(rdata_i), .data_o(data_o),
    .valid_o(valid_o), .ready_i(ready_i),
    .checksum_o(checksum_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  logic mem_cks = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem_cks) return a[2] ? 32'h0000_0002 : 32'hFFFF_FFFF;
    return a ^ 32'hA5A5_A5A5;
  endfunction

  always @(posedge clk) if (req_o) rdata_i <= mem_word(addr_o);

  logic [31:0] q[$];
  logic [31:0] exp_addr = 32'd0;
  logic [31:0] sum = 32'd0;
  logic [31:0] cks_done = 32'd0;
  logic [31:0] alog [8];
  int occ = 0, infl = 0, cyc = 0;
  int acc_n = 0, req_n = 0, done_n = 0, busy_n = 0;
  int acc_cyc = 0, done_cyc = 0, st_cyc = 0, fv_cyc = -1;

  always @(negedge clk) begin
    cyc++;
    if (!rst_ni) begin
      q.delete();
      occ = 0;
      infl = 0;
    end else begin
      chk("occ_plus_inflight_le2", 32'(occ + infl <= 2), 32'd1);
      chk("valid_vs_model", 32'(valid_o), 32'(occ != 0));
      if (valid_o && fv_cyc < 0) fv_cyc = cyc;
      if (req_o) begin
        chk("req_addr", addr_o, exp_addr);
        if (req_n < 8) alog[req_n] = addr_o;
        req_n++;
        q.push_back(mem_word(exp_addr));
        exp_addr += 32'd4;
      end
      if (valid_o && ready_i) begin
        checks++;
        assert (q.size() != 0) else begin
          errors++;
          $error("FAIL sb_underflow observed=%h expected=none", data_o);
        end
        if (q.size() != 0) chk("sb_data", data_o, q.pop_front());
        sum += data_o;
        acc_n++;
        acc_cyc = cyc;
      end
      if (done_o) begin
        done_n++;
        done_cyc = cyc;
        cks_done = checksum_o;
      end
      if (busy_o) busy_n++;
      occ = occ + infl - ((valid_o && ready_i) ? 1 : 0);
      infl = req_o ? 1 : 0;
    end
  end

  task automatic do_start(input logic [31:0] b, input logic [7:0] n);
    @(posedge clk); #1;
    exp_addr = {b[31:2], 2'b00};
    sum = 32'd0;
    acc_n = 0; req_n = 0; done_n = 0; busy_n = 0;
    fv_cyc = -1;
    st_cyc = cyc + 1;
    base_addr_i = b;
    len_i = n;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  // mode 0: ready high; 1: random; 2: low 10 cycles then random.
  // Non-zero modes also pulse a start mid-burst that must be ignored.
  task automatic wait_done(input int mode, input int maxc);
    int k = 0;
    while (done_n == 0 && k < maxc) begin
      @(posedge clk); #1;
      case (mode)
        0: ready_i = 1'b1;
        1: ready_i = 1'($urandom_range(0, 1));
        default: ready_i = (k < 10) ? 1'b0 : 1'($urandom_range(0, 1));
      endcase
      if (mode != 0 && k == 4) begin
        start_i = 1'b1;
        len_i = 8'd3;
        base_addr_i = 32'h4000_0000;
      end else begin
        start_i = 1'b0;
      end
      k++;
    end
    start_i = 1'b0;
    ready_i = 1'b1;
  endtask

  task automatic end_burst(input string tg, input int n);
    repeat (2) @(posedge clk);
    #1;
    chk({tg, "_done_once"}, done_n, 1);
    chk({tg, "_words"}, acc_n, n);
    chk({tg, "_reqs"}, req_n, n);
    chk({tg, "_sb_empty"}, q.size(), 0);
    chk({tg, "_busy_low"}, 32'(busy_o), 32'd0);
    chk({tg, "_cks"}, cks_done, CKS ? sum : 32'd0);
  endtask

  initial begin
    #12;
    chk("rst_req", 32'(req_o), 0);
    chk("rst_addr", addr_o, 0);
    chk("rst_valid", 32'(valid_o), 0);
    chk("rst_data", data_o, 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_done", 32'(done_o), 0);
    chk("rst_cks", checksum_o, 0);
    #10 rst_ni = 1'b1;

    ready_i = 1'b1;
    do_start(32'h1C00_0080, 8'd4);
    wait_done(0, 50);
    end_burst("basic", 4);
    chk("basic_a0", alog[0], 32'h1C00_0080);
    chk("basic_a1", alog[1], 32'h1C00_0084);
    chk("basic_a2", alog[2], 32'h1C00_0088);
    chk("basic_a3", alog[3], 32'h1C00_008C);
    chk("basic_latency", 32'(fv_cyc - st_cyc), 32'd3);
    chk("basic_done_after_acc", 32'(done_cyc - acc_cyc), 32'd1);

    do_start(32'h5000_0000, 8'd0);
    wait_done(0, 20);
    end_burst("len0", 0);
    chk("len0_done_lat", 32'(done_cyc - st_cyc), 32'd1);
    chk("len0_busy_cycles", busy_n, 0);

    ready_i = 1'b0;
    do_start(32'h0000_0100, 8'd6);
    wait_done(1, 200);
    end_burst("rand6", 6);

    ready_i = 1'b0;
    do_start(32'h0000_0203, 8'd6);
    wait_done(2, 200);
    end_burst("stall6", 6);
    chk("stall6_first", alog[0], 32'h0000_0200);

    ready_i = 1'b1;
    do_start(32'hFFFF_FFF8, 8'd4);
    wait_done(0, 50);
    end_burst("wrap", 4);
    chk("wrap_a0", alog[0], 32'hFFFF_FFF8);
    chk("wrap_a1", alog[1], 32'hFFFF_FFFC);
    chk("wrap_a2", alog[2], 32'h0000_0000);
    chk("wrap_a3", alog[3], 32'h0000_0004);

    do_start(32'h0000_1000, 8'd255);
    wait_done(0, 600);
    end_burst("maxlen", 255);

    do_start(32'h2000_0000, 8'd8);
    for (int k = 0; k < 50 && acc_n < 2; k++) @(posedge clk);
    #2 rst_ni = 1'b0;
    #1;
    chk("mid_rst_req", 32'(req_o), 0);
    chk("mid_rst_addr", addr_o, 0);
    chk("mid_rst_valid", 32'(valid_o), 0);
    chk("mid_rst_data", data_o, 0);
    chk("mid_rst_busy", 32'(busy_o), 0);
    chk("mid_rst_cks", checksum_o, 0);
    repeat (2) @(negedge clk);
    #2 rst_ni = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("mid_rst_no_done", done_n, 0);
    chk("mid_rst_idle_valid", 32'(valid_o), 0);
    do_start(32'h3000_0010, 8'd2);
    wait_done(0, 50);
    end_burst("after_rst", 2);

    mem_cks = 1'b1;
    do_start(32'h0000_0000, 8'd2);
    wait_done(0, 50);
    end_burst("cks", 2);
    chk("cks_value", cks_done, CKS ? 32'h0000_0001 : 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
